// File: rtl/cmprs_vsync_late_gen.sv
// Late vsync generator: issues vsync_late a programmable number of source lines into each frame.
// Optional forced-pulse timeout enabled by defining CMPRS_VSYNC_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | block disabled (en=0)
// ARMED  | waiting for a source frame start
// COUNT  | frame in progress, waiting for line_unfinished_src to reach the delay
// FIRE   | vsync_late is high this cycle
module cmprs_vsync_late_gen #(
  parameter int FRAME_HEIGHT_BITS  = 16,
  parameter int LAST_FRAME_BITS    = 16,
  parameter int DEFAULT_DELAY      = 16,
  parameter int SKIP_BITS          = 8,
  parameter int VSYNC_TIMEOUT_BITS = 20,
  parameter int VSYNC_TIMEOUT      = 500000
) (
  input  logic                         mclk,
  input  logic                         mrst,
  input  logic                         en,
  input  logic                         set_delay,
  input  logic [FRAME_HEIGHT_BITS-1:0] delay_data,
  input  logic                         frame_start_src,
  input  logic [FRAME_HEIGHT_BITS-1:0] line_unfinished_src,
  output logic                         vsync_late,
  output logic                         frame_pending,
  output logic [SKIP_BITS-1:0]         frames_skipped,
  output logic [LAST_FRAME_BITS-1:0]   vsync_count,
  output logic                         timeout_fired
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_FIRE  = 2'd3
  } state_t;

  localparam logic [FRAME_HEIGHT_BITS-1:0] DELAY_RST = FRAME_HEIGHT_BITS'(DEFAULT_DELAY);

  state_t                       state_q, state_d;
  logic [FRAME_HEIGHT_BITS-1:0] delay_reg_q, delay_reg_d;
  logic [FRAME_HEIGHT_BITS-1:0] delay_lat_q, delay_lat_d;
  logic                         line_zero_seen_q, line_zero_seen_d;
  logic                         vsync_late_q, vsync_late_d;
  logic [SKIP_BITS-1:0]         frames_skipped_q, frames_skipped_d;
  logic [LAST_FRAME_BITS-1:0]   vsync_count_q, vsync_count_d;

  logic                         line_zero;
  logic                         fire_cond;
  logic                         accept_start;
  logic                         tmo_expired;
  logic                         fire_by_timeout;
  logic [FRAME_HEIGHT_BITS-1:0] delay_next;

  assign line_zero    = (line_unfinished_src == '0);
  // A nonzero line only counts once line 0 of this frame has been observed.
  assign fire_cond    = (line_zero_seen_q | line_zero) & (line_unfinished_src >= delay_lat_q);
  assign accept_start = en & frame_start_src & (state_q != ST_IDLE);
  assign delay_next   = set_delay ? delay_data : delay_reg_q;

`ifdef CMPRS_VSYNC_TIMEOUT_EN
  localparam logic [VSYNC_TIMEOUT_BITS-1:0] TMO_LOAD = VSYNC_TIMEOUT_BITS'(VSYNC_TIMEOUT);

  logic [VSYNC_TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic                          timeout_fired_q, timeout_fired_d;

  assign tmo_expired = (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (accept_start) begin
      tmo_d = TMO_LOAD;
    end else if ((state_q == ST_COUNT) && !tmo_expired) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  always_comb begin
    timeout_fired_d = 1'b0;
    if (en && (state_q == ST_COUNT) && !frame_start_src && tmo_expired && !fire_cond) begin
      timeout_fired_d = 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      tmo_q           <= '0;
      timeout_fired_q <= 1'b0;
    end else begin
      tmo_q           <= tmo_d;
      timeout_fired_q <= timeout_fired_d;
    end
  end

  assign timeout_fired = timeout_fired_q;
`else
  assign tmo_expired   = 1'b0;
  assign timeout_fired = 1'b0;
`endif

  assign fire_by_timeout = tmo_expired & ~fire_cond;

  always_comb begin
    state_d          = state_q;
    delay_reg_d      = delay_next;
    delay_lat_d      = delay_lat_q;
    line_zero_seen_d = line_zero_seen_q;
    vsync_late_d     = 1'b0;
    frames_skipped_d = frames_skipped_q;
    vsync_count_d    = vsync_count_q;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d          = ST_ARMED;
          frames_skipped_d = '0;
        end
        ST_ARMED: begin
          if (frame_start_src) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (frame_start_src) begin
            if (!(&frames_skipped_q)) frames_skipped_d = frames_skipped_q + 1'b1;
          end else if (fire_cond | fire_by_timeout) begin
            state_d       = ST_FIRE;
            vsync_late_d  = 1'b1;
            vsync_count_d = vsync_count_q + 1'b1;
          end else if (line_zero) begin
            line_zero_seen_d = 1'b1;
          end
        end
        ST_FIRE: begin
          state_d = frame_start_src ? ST_COUNT : ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Any accepted start (ARMED, FIRE or a restart in COUNT) latches a fresh delay.
    if (accept_start) begin
      state_d          = ST_COUNT;
      delay_lat_d      = delay_next;
      line_zero_seen_d = line_zero;
    end
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q          <= ST_IDLE;
      delay_reg_q      <= DELAY_RST;
      delay_lat_q      <= DELAY_RST;
      line_zero_seen_q <= 1'b0;
      vsync_late_q     <= 1'b0;
      frames_skipped_q <= '0;
      vsync_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      delay_reg_q      <= delay_reg_d;
      delay_lat_q      <= delay_lat_d;
      line_zero_seen_q <= line_zero_seen_d;
      vsync_late_q     <= vsync_late_d;
      frames_skipped_q <= frames_skipped_d;
      vsync_count_q    <= vsync_count_d;
    end
  end

  assign vsync_late     = vsync_late_q;
  assign frame_pending  = (state_q == ST_COUNT);
  assign frames_skipped = frames_skipped_q;
  assign vsync_count    = vsync_count_q;

endmodule

// File: doc/cmprs_vsync_late_gen.md
Name: cmprs_vsync_late_gen

Overview:
- Upstream neighbour of the compressor frame-sync stage, in the mclk domain.
- Watches the sensor (source) memory channel's frame-start pulse and unfinished-line number.
- Emits a single-cycle `vsync_late` a programmable number of lines into each source frame, so sequencer commands land before compression starts.
- Also reports frames that started before the previous `vsync_late` was issued, and counts issued pulses.

Parameters:
- FRAME_HEIGHT_BITS, 16, width of line numbers and delay
- LAST_FRAME_BITS, 16, width of vsync_count (wraps)
- DEFAULT_DELAY, 16, delay in lines loaded at reset
- SKIP_BITS, 8, width of saturating frames_skipped counter
- VSYNC_TIMEOUT_BITS, 20, width of timeout counter (used only with the optional feature)
- VSYNC_TIMEOUT, 500000, mclk cycles before a forced pulse (used only with the optional feature)

Ports:
- mclk  in  1  global system/memory clock; all logic is on its posedge
- mrst  in  1  reset, asynchronous, active-high
- en  in  1  block enable; when low, the block is held idle
- set_delay  in  1  single-cycle strobe: load delay_data
- delay_data  in  FRAME_HEIGHT_BITS  new delay, in lines
- frame_start_src  in  1  single-cycle pulse: source channel started a frame
- line_unfinished_src  in  FRAME_HEIGHT_BITS  source channel's current unfinished line
- vsync_late  out  1  single-cycle pulse to the compressor frame-sync stage
- frame_pending  out  1  a frame has started and its vsync_late has not been issued yet
- frames_skipped  out  SKIP_BITS  saturating count of frames dropped without a pulse
- vsync_count  out  LAST_FRAME_BITS  number of vsync_late pulses issued, wraps
- timeout_fired  out  1  single-cycle flag: the pulse was forced by timeout

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - delay_reg = DEFAULT_DELAY; delay_lat = DEFAULT_DELAY
  - line_zero_seen = 0
- Delay registers:
  - set_delay loads delay_reg on the next edge.
  - delay_reg is copied to delay_lat on each accepted frame_start_src.
  - If set_delay and frame_start_src arrive in the same cycle, delay_data goes straight to delay_lat.
  - A delay change therefore never affects the frame already in progress.
- State machine:
  - IDLE: while en=0. On en=1, go to ARMED and clear frames_skipped to 0.
  - ARMED: frame_start_src -> COUNT; latch delay_lat; clear line_zero_seen.
  - COUNT:
    - Set line_zero_seen when line_unfinished_src==0 is sampled, including on the entry edge. This guards against stale line numbers left over from the previous frame.
    - Fire condition: line_zero_seen (or line_unfinished_src==0 this cycle) and line_unfinished_src >= delay_lat.
    - When the fire condition holds -> FIRE.
  - FIRE:
    - vsync_late = 1 for exactly this cycle (registered output).
    - vsync_count increments by 1.
    - Next state ARMED.
    - A frame_start_src arriving in this cycle is treated as an ARMED-state start (next state COUNT).
- Latency:
  - frame_start_src sampled at edge t0, delay 0, line 0 present: vsync_late is high during the cycle after edge t0+1.
  - Otherwise the pulse comes 1 cycle after the edge that samples the fire condition.
- Frame skipped:
  - If frame_start_src arrives in COUNT, frames_skipped increments, saturating at all-ones.
  - The block restarts COUNT for the new frame with a freshly latched delay.
  - frame_start_src takes priority over a fire condition in the same cycle; no pulse is issued for the old frame.
- frame_pending: high in COUNT, low in IDLE, ARMED and FIRE.
- en falls (any state):
  - Next edge -> IDLE.
  - No vsync_late, even if FIRE was pending.
  - frames_skipped and vsync_count hold their values.
- A delay larger than any line reached means no pulse for that frame. The next frame_start_src counts that frame as skipped.
- Asserting mrst mid-frame returns the block to reset values immediately.

Optional Feature:
- Macro: CMPRS_VSYNC_TIMEOUT_EN
- Defined:
  - A timeout counter loads VSYNC_TIMEOUT on entering COUNT and decrements each cycle while in COUNT.
  - When it reaches 0 without the fire condition, the block goes to FIRE and timeout_fired pulses together with vsync_late.
  - A frame_start_src in the same cycle still takes priority.
- Undefined:
  - No counter is built.
  - timeout_fired is tied to 0.

Test Plan:
- Reset then en=1, default delay 16; frame_start_src with line counting 0..40, one line per 10 cycles -> one vsync_late, 1 cycle after line 16 is sampled; vsync_count=1; frame_pending low afterwards.
- set_delay=5 mid-frame (delay 16 active) -> the current frame fires at line 16; the next frame fires at line 5.
- delay=0, line_unfinished_src already 0 at frame_start_src edge t0 -> vsync_late high in the cycle after edge t0+1.
- Stale line_unfinished_src=300 at frame_start (delay 16) -> no pulse until the line drops to 0 and then reaches 16.
- Second frame_start_src while in COUNT (delay 100, line 50), repeated 300 times -> frames_skipped saturates at 255; no vsync_late for the dropped frames; en 0->1 clears frames_skipped to 0.
- With CMPRS_VSYNC_TIMEOUT_EN, VSYNC_TIMEOUT=100 and a frozen line number -> vsync_late and timeout_fired pulse 101 cycles after frame_start_src. Without the macro -> no pulse, and timeout_fired stays 0.
